// File: rtl/router_pkg.sv
`timescale 1ns/1ps
// Shared router definitions: FSM state codes, header layout and header builder.
// No logic, so no latency; no flow control.
package router_pkg;

    localparam int HDR_LEN_W  = 6;
    localparam int HDR_ADDR_W = 2;

    localparam logic [HDR_ADDR_W-1:0] ADDR_INVALID = 2'b11;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD     = 3'd1;
    localparam logic [2:0] ST_SEND_HDR = 3'd2;
    localparam logic [2:0] ST_SEND_PL  = 3'd3;
    localparam logic [2:0] ST_SEND_PAR = 3'd4;

    typedef struct packed {
        logic [HDR_LEN_W-1:0]  len;
        logic [HDR_ADDR_W-1:0] addr;
    } hdr_t;

    function automatic hdr_t build_hdr(input logic [HDR_LEN_W-1:0]  len,
                                       input logic [HDR_ADDR_W-1:0] addr);
        hdr_t h;
        h.len  = len;
        h.addr = addr;
        return h;
    endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
`timescale 1ns/1ps
// Client request/payload stream plus router-side byte bus of the packet transmitter.
// master = client/router side, slave = transmitter; busy is the router's only backpressure.
interface router_pkt_tx_if;
    import router_pkg::*;

    logic                  start;
    logic [HDR_ADDR_W-1:0] dest_addr;
    logic [HDR_LEN_W-1:0]  payload_len;
    logic [7:0]            pl_data;
    logic                  pl_valid;
    logic                  pl_ready;
    logic                  busy;
    logic [7:0]            data_in;
    logic                  pkt_valid;
    logic                  tx_active;
    logic                  done;
    logic                  req_err;
`ifdef ROUTER_PKT_TX_PARITY_INJ_EN
    logic                  inj_par_err;

    modport master (
        output start, dest_addr, payload_len, pl_data, pl_valid, busy, inj_par_err,
        input  pl_ready, data_in, pkt_valid, tx_active, done, req_err
    );
    modport slave (
        input  start, dest_addr, payload_len, pl_data, pl_valid, busy, inj_par_err,
        output pl_ready, data_in, pkt_valid, tx_active, done, req_err
    );
`else
    modport master (
        output start, dest_addr, payload_len, pl_data, pl_valid, busy,
        input  pl_ready, data_in, pkt_valid, tx_active, done, req_err
    );
    modport slave (
        input  start, dest_addr, payload_len, pl_data, pl_valid, busy,
        output pl_ready, data_in, pkt_valid, tx_active, done, req_err
    );
`endif

endinterface

// File: rtl/router_tx_buf.sv
`timescale 1ns/1ps
// Payload store: 2**AW x 8 registers, synchronous write, asynchronous (same-cycle) read.
// No flow control; the writer owns the write enable. Contents are not reset.
module router_tx_buf #(
    parameter int AW = 6
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [2**AW];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/router_pkt_tx.sv
`timescale 1ns/1ps
// Buffers a whole payload, then emits header/payload/parity to the router; registered outputs.
// Router busy holds every output; ROUTER_PKT_TX_PARITY_INJ_EN adds inj_par_err (parity ^ 8'h01).
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int MAX_LEN = 63,
    parameter int BUF_AW  = 6
) (
    input  logic           clock,
    input  logic           resetn,
    router_pkt_tx_if.slave bus
);

    localparam logic [HDR_LEN_W-1:0] MAX_LEN_L = HDR_LEN_W'(MAX_LEN);

    logic [2:0]        state_q;
    hdr_t              hdr_q;
    logic [BUF_AW-1:0] wr_ptr;
    logic [BUF_AW-1:0] rd_ptr;
    logic [7:0]        parity_q;
    logic [7:0]        data_q;
    logic              pkt_valid_q;
    logic              done_q;
    logic              req_err_q;
    logic [7:0]        par_out;
    logic [7:0]        buf_rdata;
    logic              buf_we;
    logic              len_ok;
    logic              start_ok;
    logic [BUF_AW-1:0] len_ext;
    logic [BUF_AW-1:0] len_last;

    // A 6-bit length can never exceed a 63-byte limit, so only test the upper bound when it binds.
    if (MAX_LEN >= (2**HDR_LEN_W) - 1) begin : g_len_full
        assign len_ok = |bus.payload_len;
    end else begin : g_len_cap
        assign len_ok = (|bus.payload_len) && (bus.payload_len <= MAX_LEN_L);
    end

    assign start_ok = len_ok && (bus.dest_addr != ADDR_INVALID);
    assign len_ext  = BUF_AW'(hdr_q.len);
    assign len_last = len_ext - BUF_AW'(1);
    assign buf_we   = (state_q == ST_LOAD) && bus.pl_valid;

`ifdef ROUTER_PKT_TX_PARITY_INJ_EN
    logic inj_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            inj_q <= 1'b0;
        end else if (state_q == ST_IDLE && bus.start && start_ok) begin
            inj_q <= bus.inj_par_err;
        end
    end

    assign par_out = parity_q ^ {7'd0, inj_q};
`else
    assign par_out = parity_q;
`endif

    router_tx_buf #(
        .AW (BUF_AW)
    ) u_buf (
        .clock (clock),
        .we    (buf_we),
        .waddr (wr_ptr),
        .wdata (bus.pl_data),
        .raddr (rd_ptr),
        .rdata (buf_rdata)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            hdr_q       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            parity_q    <= '0;
            data_q      <= '0;
            pkt_valid_q <= 1'b0;
            done_q      <= 1'b0;
            req_err_q   <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            req_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (start_ok) begin
                            hdr_q    <= build_hdr(bus.payload_len, bus.dest_addr);
                            parity_q <= build_hdr(bus.payload_len, bus.dest_addr);
                            wr_ptr   <= '0;
                            rd_ptr   <= '0;
                            state_q  <= ST_LOAD;
                        end else begin
                            req_err_q <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (bus.pl_valid) begin
                        parity_q <= parity_q ^ bus.pl_data;
                        wr_ptr   <= wr_ptr + 1'b1;
                        if (wr_ptr == len_last) begin
                            data_q      <= hdr_q;
                            pkt_valid_q <= 1'b1;
                            state_q     <= ST_SEND_HDR;
                        end
                    end
                end
                ST_SEND_HDR: begin
                    // rd_ptr is still 0 here, so buf_rdata is the first payload byte
                    if (!bus.busy) begin
                        data_q  <= buf_rdata;
                        rd_ptr  <= BUF_AW'(1);
                        state_q <= ST_SEND_PL;
                    end
                end
                ST_SEND_PL: begin
                    if (!bus.busy) begin
                        if (rd_ptr == len_ext) begin
                            data_q      <= par_out;
                            pkt_valid_q <= 1'b0;
                            state_q     <= ST_SEND_PAR;
                        end else begin
                            data_q <= buf_rdata;
                            rd_ptr <= rd_ptr + 1'b1;
                        end
                    end
                end
                ST_SEND_PAR: begin
                    if (!bus.busy) begin
                        done_q  <= 1'b1;
                        data_q  <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.pl_ready  = (state_q == ST_LOAD);
    assign bus.data_in   = data_q;
    assign bus.pkt_valid = pkt_valid_q;
    assign bus.tx_active = (state_q != ST_IDLE);
    assign bus.done      = done_q;
    assign bus.req_err   = req_err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
`timescale 1ns/1ps
// Directed and randomized packets checked against a byte-stream model of the router packet.
module tb_router_pkt_tx;
    import router_pkg::*;

    logic clock = 1'b0;
    logic resetn;

    always #5 clock = ~clock;

    router_pkt_tx_if bus ();

    router_pkt_tx #(
        .MAX_LEN (63),
        .BUF_AW  (6)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] pl_arr [64];
    logic [7:0] exp_b [$];
    logic       exp_v [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.start       = 1'b0;
        bus.dest_addr   = 2'd0;
        bus.payload_len = 6'd0;
        bus.pl_data     = 8'd0;
        bus.pl_valid    = 1'b0;
        bus.busy        = 1'b0;
`ifdef ROUTER_PKT_TX_PARITY_INJ_EN
        bus.inj_par_err = 1'b0;
`endif
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_data_in"},   32'(bus.data_in),   32'd0);
        chk({tag, "_pkt_valid"}, 32'(bus.pkt_valid), 32'd0);
        chk({tag, "_pl_ready"},  32'(bus.pl_ready),  32'd0);
        chk({tag, "_tx_active"}, 32'(bus.tx_active), 32'd0);
        chk({tag, "_done"},      32'(bus.done),      32'd0);
        chk({tag, "_req_err"},   32'(bus.req_err),   32'd0);
    endtask

    task automatic set_fixed();
        pl_arr[0] = 8'h11;
        pl_arr[1] = 8'h22;
        pl_arr[2] = 8'h33;
        pl_arr[3] = 8'h44;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 64; i++) pl_arr[i] = 8'($urandom);
    endtask

    // vmode: 0 always valid, 1 every other cycle, 2 random.
    // bmode: 0 never busy, 1 three-cycle stalls at header and payload byte 7, 2 random.
    task automatic run_pkt(input int len, input int addr, input int vmode, input int bmode,
                           input int abort_at, input logic inj);
        logic [7:0] par;
        logic       vld;
        logic       b;
        int         cnt;
        int         cyc;
        int         idx;
        int         hold;
        int         last_idx;

        par = 8'(len * 4 + addr);
        exp_b.delete();
        exp_v.delete();
        exp_b.push_back(par);
        exp_v.push_back(1'b1);
        for (int i = 0; i < len; i++) begin
            exp_b.push_back(pl_arr[i]);
            exp_v.push_back(1'b1);
            par = par ^ pl_arr[i];
        end
        exp_b.push_back(par ^ {7'd0, inj});
        exp_v.push_back(1'b0);

        @(negedge clock);
        bus.start       = 1'b1;
        bus.dest_addr   = 2'(addr);
        bus.payload_len = 6'(len);
`ifdef ROUTER_PKT_TX_PARITY_INJ_EN
        bus.inj_par_err = inj;
`endif
        @(negedge clock);
        bus.start = 1'b0;
        chk("tx_active_accept", 32'(bus.tx_active), 32'd1);

        cnt = 0;
        cyc = 0;
        while (cnt < len && cyc < 1000) begin
            chk("pl_ready_load", 32'(bus.pl_ready), 32'd1);
            chk("pkt_valid_load", 32'(bus.pkt_valid), 32'd0);
            if (vmode == 0)      vld = 1'b1;
            else if (vmode == 1) vld = (cyc % 2 == 0);
            else                 vld = 1'($urandom_range(0, 1));
            bus.pl_valid = vld;
            bus.pl_data  = vld ? pl_arr[cnt] : 8'($urandom);
            bus.busy     = 1'($urandom_range(0, 1));
            if (vld) cnt++;
            @(negedge clock);
            cyc++;
        end
        if (cyc >= 1000) chk("load_timeout", 32'd1, 32'd0);
        bus.pl_valid = 1'b0;
        chk("pl_ready_after_load", 32'(bus.pl_ready), 32'd0);

        idx      = 0;
        cyc      = 0;
        hold     = 0;
        last_idx = -1;
        while (idx < len + 2 && cyc < 2000) begin
            if (idx == abort_at) begin
                resetn = 1'b0;
                #1;
                chk_reset_vals("abort");
                @(negedge clock);
                resetn = 1'b1;
                return;
            end
            chk("data_in", 32'(bus.data_in), 32'(exp_b[idx]));
            chk("pkt_valid", 32'(bus.pkt_valid), 32'(exp_v[idx]));
            chk("tx_active_send", 32'(bus.tx_active), 32'd1);
            if (idx != last_idx) begin
                hold     = 0;
                last_idx = idx;
            end
            if (bmode == 0)      b = 1'b0;
            else if (bmode == 1) b = (idx == 0 || idx == 7) && hold < 3;
            else                 b = ($urandom_range(0, 3) == 0);
            bus.busy = b;
            hold++;
            if (!b) idx++;
            @(negedge clock);
            cyc++;
        end
        if (cyc >= 2000) chk("send_timeout", 32'd1, 32'd0);
        bus.busy = 1'($urandom_range(0, 1));
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("tx_active_end", 32'(bus.tx_active), 32'd0);
        chk("data_in_end", 32'(bus.data_in), 32'd0);
        chk("pkt_valid_end", 32'(bus.pkt_valid), 32'd0);
        @(negedge clock);
        chk("done_single", 32'(bus.done), 32'd0);
        bus.busy = 1'b0;
    endtask

    task automatic reject(input int len, input int addr);
        @(negedge clock);
        bus.start       = 1'b1;
        bus.dest_addr   = 2'(addr);
        bus.payload_len = 6'(len);
        @(negedge clock);
        bus.start = 1'b0;
        chk("req_err_pulse", 32'(bus.req_err), 32'd1);
        chk("reject_tx_active", 32'(bus.tx_active), 32'd0);
        chk("reject_pkt_valid", 32'(bus.pkt_valid), 32'd0);
        chk("reject_pl_ready", 32'(bus.pl_ready), 32'd0);
        @(negedge clock);
        chk("req_err_single", 32'(bus.req_err), 32'd0);
        chk("reject_idle", 32'(bus.tx_active), 32'd0);
    endtask

    initial begin
        idle_inputs();
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        chk_reset_vals("reset");
        resetn = 1'b1;

        set_fixed();
        run_pkt(4, 1, 0, 0, -1, 1'b0);

        fill_rand();
        run_pkt(14, 1, 0, 1, -1, 1'b0);

        fill_rand();
        run_pkt(63, 2, 1, 0, -1, 1'b0);

        reject(0, 1);
        reject(5, 3);

        fill_rand();
        run_pkt(16, 0, 0, 0, 5, 1'b0);
        set_fixed();
        run_pkt(4, 1, 0, 0, -1, 1'b0);

`ifdef ROUTER_PKT_TX_PARITY_INJ_EN
        set_fixed();
        run_pkt(4, 1, 0, 0, -1, 1'b1);
        chk("inj_parity_value", 32'(exp_b[5]), 32'h54);
`endif

        fill_rand();
        run_pkt(1, 0, 0, 2, -1, 1'b0);

        for (int n = 0; n < 6; n++) begin
            fill_rand();
            run_pkt(int'($urandom_range(1, 63)), int'($urandom_range(0, 2)), 2, 2, -1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
